// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM encoding (BOOT / RUN / HALT)
//   fault_cause_e : codes reported on fault_cause
//   INSTR_BYTES   : PC increment per instruction
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10
  } fault_cause_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instr_fetch_stage_ifid_reg.sv
// IF/ID pipeline register with load / hold / flush.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   load                : capture src_pc / src_instr, set valid
//   flush               : clear valid (data fields keep their value)
//   src_pc, src_instr   : PC and ROM word of the instruction being fetched
//   valid, pc, pc_plus4, instr : registered outputs towards decode
// Neither load nor flush means hold.
module ifid_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] src_pc,
  input  logic [31:0] src_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= src_pc;
      pc_plus4 <= src_pc + INSTR_BYTES;
      instr    <= src_instr;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC register, fetch FSM, fault capture and the IF/ID register.
// Optional performance counters are built only when the macro
// INSTR_FETCH_PERF_EN is defined; otherwise perf_* are tied to zero.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   stall                        : hold PC and IF/ID
//   redirect_valid, redirect_pc  : taken branch/jump and its target
//   fetch_pc / instr_in          : ROM address out, ROM data back (same cycle)
//   ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr : IF/ID register
//   fault, fault_pc, fault_cause : sticky fetch fault report
//   perf_fetched, perf_stalls    : saturating event counters
//
// state | meaning
// BOOT  | single cycle after reset release, no fetch
// RUN   | normal fetch, redirect and stall handling
// HALT  | fault taken, frozen until reset
module instr_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  input  logic [31:0] instr_in,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  fault_cause,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);

  fetch_state_e state_q, state_d;
  fault_cause_e cause_q, cause_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic         fault_q, fault_set;
  logic         load, flush, out_of_range;

  // Word index compare; 0xFFFF_FFFC is out of range, so pc + 4 never wraps into a fetch.
  assign out_of_range = (pc_q[31:2] >= 30'(MEM_WORDS));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    fault_pc_d = fault_pc_q;
    fault_set  = 1'b0;
    load       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          state_d    = ST_HALT;
          fault_set  = 1'b1;
          cause_d    = FC_MISALIGN;
          fault_pc_d = redirect_pc;
          flush      = 1'b1;
        end else if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (out_of_range) begin
          state_d    = ST_HALT;
          fault_set  = 1'b1;
          cause_d    = FC_RANGE;
          fault_pc_d = pc_q;
          flush      = 1'b1;
        end else if (!stall) begin
          load = 1'b1;
          pc_d = pc_q + INSTR_BYTES;
        end
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      cause_q    <= FC_NONE;
      fault_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fault_set) begin
        fault_q    <= 1'b1;
        cause_q    <= cause_d;
        fault_pc_q <= fault_pc_d;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (flush),
    .src_pc   (pc_q),
    .src_instr(instr_in),
    .valid    (ifid_valid),
    .pc       (ifid_pc),
    .pc_plus4 (ifid_pc_plus4),
    .instr    (ifid_instr)
  );

  assign fetch_pc    = pc_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fault_cause = cause_q;

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fetched_q, stalls_q;
  logic        stall_evt;

  assign stall_evt = (state_q == ST_RUN) && stall && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (load && (fetched_q != 32'hFFFF_FFFF)) fetched_q <= fetched_q + 32'd1;
      if (stall_evt && (stalls_q != 32'hFFFF_FFFF)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic [31:0] instr_in;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  fault_cause;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;

  logic [31:0] rom [32];
  int n_vec = 0;
  int n_err = 0;

  instr_fetch_stage #(.RESET_PC(32'h0), .MEM_WORDS(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_pc      (fetch_pc),
    .instr_in      (instr_in),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fault_cause   (fault_cause),
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    instr_in = 32'h0;
    if (fetch_pc[31:7] == 25'd0) instr_in = rom[fetch_pc[6:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " fetch_pc"}, fetch_pc, 32'h0);
    chk({tag, " valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, " ifid_pc"}, ifid_pc, 32'h0);
    chk({tag, " pc_plus4"}, ifid_pc_plus4, 32'h0);
    chk({tag, " instr"}, ifid_instr, 32'h0);
    chk({tag, " fault"}, {31'd0, fault}, 32'd0);
    chk({tag, " fault_pc"}, fault_pc, 32'h0);
    chk({tag, " cause"}, {30'd0, fault_cause}, 32'd0);
    chk({tag, " perf_f"}, perf_fetched, 32'h0);
    chk({tag, " perf_s"}, perf_stalls, 32'h0);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, " valid"}, {31'd0, ifid_valid}, 32'd1);
    chk({tag, " ifid_pc"}, ifid_pc, pc);
    chk({tag, " pc_plus4"}, ifid_pc_plus4, pc + 32'd4);
    chk({tag, " instr"}, ifid_instr, ins);
  endtask

  // Releases reset #1 after a posedge; the next edge is the BOOT cycle.
  task automatic release_and_boot();
    rst_n = 1'b1;
    tick();
    chk("boot valid", {31'd0, ifid_valid}, 32'd0);
    chk("boot fetch_pc", fetch_pc, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + i;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    rom[4] = 32'h0;

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    chk_reset_vals("reset");

    // Boot bubble and first fetches
    release_and_boot();
    tick(); chk_ifid("f0", 32'h0, 32'h11); chk("f0 fetch_pc", fetch_pc, 32'h4);
    tick(); chk_ifid("f1", 32'h4, 32'h22); chk("f1 fetch_pc", fetch_pc, 32'h8);

    // Three stall cycles at pc = 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall fetch_pc", fetch_pc, 32'h8);
      chk_ifid("stall", 32'h4, 32'h22);
    end
`ifdef INSTR_FETCH_PERF_EN
    chk("perf_stalls", perf_stalls, 32'd3);
    chk("perf_fetched", perf_fetched, 32'd2);
`else
    chk("perf_stalls off", perf_stalls, 32'd0);
    chk("perf_fetched off", perf_fetched, 32'd0);
`endif
    stall = 1'b0;
    tick(); chk_ifid("f2", 32'h8, 32'h33);
    tick(); chk_ifid("f3", 32'hC, 32'h44);
    tick(); chk_ifid("f4 zero", 32'h10, 32'h0);
    chk("zero no fault", {31'd0, fault}, 32'd0);
    chk("f4 fetch_pc", fetch_pc, 32'h14);

    // Redirect overrides stall, one bubble
    redirect_valid = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
    tick();
    chk("redir fetch_pc", fetch_pc, 32'h10);
    chk("redir flush", {31'd0, ifid_valid}, 32'd0);
    redirect_valid = 1'b0; stall = 1'b0;
    tick(); chk_ifid("redir tgt", 32'h10, 32'h0);
    tick(); chk_ifid("redir +1", 32'h14, 32'hA000_0005);
    chk("pre-fault fetch_pc", fetch_pc, 32'h18);

    // Misaligned redirect -> HALT
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick();
    chk("mis fault", {31'd0, fault}, 32'd1);
    chk("mis cause", {30'd0, fault_cause}, 32'd1);
    chk("mis fault_pc", fault_pc, 32'h6);
    chk("mis valid", {31'd0, ifid_valid}, 32'd0);
    chk("mis fetch_pc", fetch_pc, 32'h18);
    redirect_pc = 32'h20;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halt fetch_pc", fetch_pc, 32'h18);
      chk("halt valid", {31'd0, ifid_valid}, 32'd0);
      chk("halt cause", {30'd0, fault_cause}, 32'd1);
      chk("halt fault_pc", fault_pc, 32'h6);
    end
    redirect_valid = 1'b0;

    // Asynchronous reset while in HALT
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst halt");
    tick();

    // Sequential run off the end of the ROM
    release_and_boot();
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("seq ifid_pc", ifid_pc, 32'(i * 4));
      chk("seq instr", ifid_instr, rom[i]);
    end
    chk("seq fetch_pc", fetch_pc, 32'h80);
    tick();
    chk("range fault", {31'd0, fault}, 32'd1);
    chk("range cause", {30'd0, fault_cause}, 32'd2);
    chk("range fault_pc", fault_pc, 32'h80);
    chk("range valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("range frozen", fetch_pc, 32'h80);

    // Top-of-address-space target faults, never wraps to 0
    #3 rst_n = 1'b0;
    tick();
    release_and_boot();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("top fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    chk("top valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("top cause", {30'd0, fault_cause}, 32'd2);
    chk("top fault_pc", fault_pc, 32'hFFFF_FFFC);
    chk("top fetch_pc hold", fetch_pc, 32'hFFFF_FFFC);

    // Asynchronous reset mid-stall, then restart at RESET_PC
    #3 rst_n = 1'b0;
    tick();
    release_and_boot();
    tick(); chk_ifid("r0", 32'h0, 32'h11);
    tick(); chk_ifid("r1", 32'h4, 32'h22);
    stall = 1'b1;
    tick(); chk("rstall fetch_pc", fetch_pc, 32'h8);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst stall");
    stall = 1'b0;
    tick();
    release_and_boot();
    tick(); chk_ifid("restart", 32'h0, 32'h11);
    chk("restart fetch_pc", fetch_pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- IF stage of the core: owns the PC register, drives the fetch address into the combinational instruction ROM, and registers {pc, instr} into the IF/ID pipeline register for the decoder.
- Handles decode/execute stall, branch/jump redirect with flush, and fetch faults: misaligned target, or PC outside ROM range.
- Sits between the branch unit / hazard logic (upstream) and the decode stage (downstream).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 32, ROM depth in words; a PC with pc>>2 >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and IF/ID register.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target address.
- fetch_pc  out  32  address to ROM, combinational copy of the PC register.
- instr_in  in  32  ROM data for fetch_pc, same cycle.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of the registered instruction.
- ifid_pc_plus4  out  32  ifid_pc + 4.
- ifid_instr  out  32  registered instruction.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  offending address.
- fault_cause  out  2  00 none, 01 misaligned redirect, 10 out of range.
- perf_fetched  out  32  count of instructions fetched (optional feature).
- perf_stalls  out  32  count of stall cycles (optional feature).

Behaviour:
- Reset (asynchronous, any state, including mid-stall or in HALT):
  - pc = RESET_PC, state = BOOT.
  - ifid_valid = 0; ifid_pc, ifid_pc_plus4, ifid_instr = 0.
  - fault = 0, fault_pc = 0, fault_cause = 00.
  - perf counters = 0.
- States: BOOT, RUN, HALT.
- BOOT: exactly one cycle after rst_n deasserts. PC held, ifid_valid = 0. Then RUN, unconditionally.
- RUN, per cycle, in priority order:
  1. redirect_valid with redirect_pc[1:0] != 0:
     - HALT; fault = 1; fault_cause = 01; fault_pc = redirect_pc.
     - ifid_valid = 0; PC unchanged.
  2. redirect_valid with target aligned:
     - pc <= redirect_pc; ifid_valid <= 0 (flush).
     - Redirect overrides stall.
  3. PC out of range (pc>>2 >= MEM_WORDS):
     - HALT; fault_cause = 10; fault_pc = pc; ifid_valid <= 0.
  4. stall: PC and all IF/ID outputs hold their values, including ifid_valid.
  5. Otherwise:
     - ifid_instr <= instr_in; ifid_pc <= pc; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1.
     - pc <= pc + 4.
- Fetch latency: instruction at PC P appears on IF/ID one cycle after fetch_pc = P.
- Taken redirect costs one bubble: the target instruction is registered in the cycle after the redirect.
- Arithmetic is 32-bit and wraps modulo 2^32. With the range check, 0xFFFF_FFFC + 4 never issues a fetch.
- HALT:
  - Sticky until reset; ignores stall and redirect.
  - ifid_valid = 0; PC frozen; fault = 1.
- ROM returning 0 is not a fault. It is passed to decode as a normal instruction.

Optional Feature:
- Macro: INSTR_FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on every IF/ID load with ifid_valid <= 1.
  - perf_stalls increments on every RUN cycle where stall = 1 and no redirect.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Shared package riscv_pkg:
  - fetch state encoding (BOOT/RUN/HALT);
  - fault_cause codes;
  - constant INSTR_BYTES = 4.
- One natural sub-module: ifid_reg (IF/ID pipeline register with load/hold/flush).
- PC logic and the FSM stay in the top module.

Test Plan:
- Reset, then release with ROM[0..3] = 11,22,33,44 (hex): BOOT bubble, then ifid_pc = 0,4,8,C on consecutive cycles with matching instrs; ifid_pc_plus4 = ifid_pc + 4.
- stall held 3 cycles at pc = 8: fetch_pc stays 8, IF/ID frozen with ifid_pc = 4; resumes with 8. perf_stalls = 3 when INSTR_FETCH_PERF_EN is defined.
- redirect_valid and stall together, redirect_pc = 0x10: next cycle fetch_pc = 0x10 and ifid_valid = 0; following cycle ifid_pc = 0x10.
- redirect_pc = 0x0000_0006: fault = 1, fault_cause = 01, fault_pc = 6; stays in HALT across later redirects.
- Sequential run to pc = 0x80 with MEM_WORDS = 32: fault_cause = 10, fault_pc = 0x80, ifid_valid = 0.
- Assert rst_n low mid-stall and in HALT: all outputs return to reset values immediately (asynchronous), and fetch restarts at RESET_PC.
